// File: rtl/con_ff_unit.sv
// Branch-condition flip-flop: evaluates the IR condition field against the bus,
// commits into CON (1 or 2 cycles after con_in), publishes via valid/ack, and keeps saturating stats.
module con_ff_unit #(
  parameter int DATA_W   = 32,
  parameter int IR_W     = 32,
  parameter int COND_LSB = 19,
  parameter int COND_W   = 3,
  parameter int PIPE     = 0,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              con_in,
  input  logic [IR_W-1:0]   ir,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              con_ack,
  input  logic              stat_clr,
  output logic              con,
  output logic              con_valid,
  output logic [CNT_W-1:0]  eval_cnt,
  output logic [CNT_W-1:0]  taken_cnt
);

  typedef enum logic {IDLE = 1'b0, HELD = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [COND_W-1:0] code;
  logic [2:0]        code_x;
  logic              z, n, eval_res;
  logic              commit, commit_res;
  logic              unused_ir;

  state_t            state_q, state_d;
  logic              con_q, con_d;
  logic [CNT_W-1:0]  eval_q, eval_d;
  logic [CNT_W-1:0]  taken_q, taken_d;

  assign code      = ir[COND_LSB +: COND_W];
  assign code_x    = 3'(code);
  assign z         = (bus_in == '0);
  assign n         = bus_in[DATA_W-1];
  assign unused_ir = ^ir;

  // With COND_W=2 code_x never exceeds 3, so legacy behaviour falls out directly.
  always_comb begin
    eval_res = 1'b0;
    case (code_x)
      3'd0: eval_res = z;
      3'd1: eval_res = !z;
      3'd2: eval_res = !n;
      3'd3: eval_res = n;
      3'd4: eval_res = !n && !z;
      3'd5: eval_res = n || z;
      3'd6: eval_res = 1'b1;
      3'd7: eval_res = 1'b0;
      default: eval_res = 1'b0;
    endcase
  end

  generate
    if (PIPE != 0) begin : g_pipe
      logic stg_vld_q, stg_res_q;
      always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
          stg_vld_q <= 1'b0;
          stg_res_q <= 1'b0;
        end else begin
          stg_vld_q <= con_in;
          stg_res_q <= eval_res;
        end
      end
      assign commit     = stg_vld_q;
      assign commit_res = stg_res_q;
    end else begin : g_direct
      assign commit     = con_in;
      assign commit_res = eval_res;
    end
  endgenerate

  // A commit always wins over ack; an unacked result is simply overwritten.
  always_comb begin
    state_d = state_q;
    con_d   = con_q;
    eval_d  = eval_q;
    taken_d = taken_q;
    if (commit) begin
      state_d = HELD;
      con_d   = commit_res;
    end else if (con_ack) begin
      state_d = IDLE;
    end
    if (stat_clr) begin
      eval_d  = '0;
      taken_d = '0;
    end else if (commit) begin
      if (eval_q != CNT_MAX) eval_d = eval_q + CNT_W'(1);
      if (commit_res && (taken_q != CNT_MAX)) taken_d = taken_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      con_q   <= 1'b0;
      eval_q  <= '0;
      taken_q <= '0;
    end else begin
      state_q <= state_d;
      con_q   <= con_d;
      eval_q  <= eval_d;
      taken_q <= taken_d;
    end
  end

  assign con       = con_q;
  assign con_valid = (state_q == HELD);
  assign eval_cnt  = eval_q;
  assign taken_cnt = taken_q;

endmodule

// File: doc/con_ff_unit.md
Name: con_ff_unit

Overview:
Parametrised successor to the single-bit branch condition flip-flop in the datapath. It decodes the condition field of the IR and evaluates it against the bus value. The result is registered into CON on the CONin strobe, and a valid/ack handshake publishes it to the control unit. It adds extended conditions (gt/le/always/never), configurable widths, an optional extra pipeline stage, and saturating taken/evaluated statistics counters.

Parameters:
DATA_W, 32, width of bus operand; sign bit is bus_in[DATA_W-1]
IR_W, 32, width of instruction register input
COND_LSB, 19, bit position of the condition field LSB within ir
COND_W, 3, condition field width; 2 = legacy 4-code mode, 3 = extended 8-code mode (other values illegal)
PIPE, 0, 0 = CON updates 1 cycle after con_in; 1 = 2 cycles
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  system clock, rising edge
clr  in  1  asynchronous active-high reset
con_in  in  1  capture strobe: evaluate condition this cycle
ir  in  IR_W  instruction register
bus_in  in  DATA_W  bus value under test
con_ack  in  1  consumer has taken CON
stat_clr  in  1  synchronous clear of both counters
con  out  1  registered branch condition
con_valid  out  1  con holds an unconsumed result
eval_cnt  out  CNT_W  number of completed evaluations
taken_cnt  out  CNT_W  number of completed evaluations with result 1

Behaviour:
- Reset (clr=1, asynchronous): con=0, con_valid=0, eval_cnt=0, taken_cnt=0, pipe stage cleared. Reset mid-evaluation discards the in-flight result.
- Condition code c = ir[COND_LSB+COND_W-1 : COND_LSB]; z = (bus_in==0); n = bus_in[DATA_W-1].
- Codes: 0 eq (z); 1 ne (!z); 2 ge (!n); 3 lt (n); 4 gt (!n & !z); 5 le (n | z); 6 always (1); 7 never (0).
- COND_W=2: only codes 0-3 exist; results are identical to the legacy block.
- Evaluation is combinational on ir/bus_in in the con_in cycle. Both inputs are sampled only in that cycle.
- PIPE=0: the result is written to con at the edge ending the con_in cycle.
- PIPE=1: the result and a strobe are registered once, then written one edge later. A back-to-back con_in every cycle is supported with throughput 1/cycle and in-order results.
- con holds its value until the next completed evaluation. It is never cleared by ack.
- "Completed evaluation" means the cycle in which con is written (commit).
- Handshake FSM, states IDLE (con_valid=0) and HELD (con_valid=1):
  - IDLE -> HELD on commit.
  - HELD -> IDLE on con_ack with no commit.
  - HELD with commit stays HELD with new con; commit wins over a simultaneous ack, and the old result is overwritten, not queued.
  - con_ack in IDLE is ignored.
- Counters: eval_cnt increments by 1 on each commit; taken_cnt increments by 1 on commit with result 1.
  - Both saturate at 2^CNT_W-1; no wrap.
  - stat_clr zeroes both at the next edge and takes priority over a same-cycle increment.
- There are no combinational paths from inputs to con or con_valid.

Test Plan:
- Reset then idle: clr pulse with no con_in -> con=0, con_valid=0, counts=0 for 10 cycles; con_ack alone does not change state.
- Legacy codes (COND_W=2, PIPE=0): c=0 with bus=0 -> con=1 next cycle; c=1 with bus=0 -> 0; c=2 with bus=0x80000000 -> 0; c=3 with bus=0xFFFFFFFF -> 1; con_valid=1 after each until acked.
- Extended codes (COND_W=3): c=4 with bus=0 -> 0; c=4 with bus=5 -> 1; c=5 with bus=0 -> 1; c=6 -> 1; c=7 -> 0; after the 5 evals eval_cnt=5 and taken_cnt=3.
- Handshake collision: commit with result 1 -> HELD; then con_in (c=7) and con_ack in the same cycle -> con=0, con_valid stays 1; a further ack -> con_valid=0.
- PIPE=1 streaming: con_in on 4 consecutive cycles with codes 0,1,6,7 and bus=0 -> con sequence 1,0,1,0 on cycles 2-5 after the first strobe; clr asserted in cycle 3 -> all outputs 0 immediately and no later commits.
- Counter saturation (CNT_W=3): 9 commits of code 6 -> eval_cnt=taken_cnt=7; stat_clr together with a commit -> both 0.
